// File: rtl/sd_sector_sample_buffer.sv
// sd_sector_sample_buffer
// Captures 512-byte sector payloads from the SD SPI reader into a two-bank
// ping-pong RAM, steps the reader's sector address after every sector that
// was fully stored, and plays the stored bytes out as unsigned 8-bit PCM at
// a fixed tick rate.
//
// Handshake: there is no ready back-pressure toward the reader. A sector is
// offered by SD_DataEnable going high and each byte by a rising edge of
// SD_DataClock. The sector counts as accepted only once a free bank has
// stored all 512 bytes. Only then does SD_Address advance, which makes the
// reader re-fetch any dropped or truncated sector.
module sd_sector_sample_buffer #(
   parameter int          MasterFrequency = 100000000,
   parameter int          SampleRate      = 44100,
   parameter logic [23:0] StartAddress    = 24'h000000,
   parameter logic [23:0] EndAddress      = 24'h0FFFFE,
   parameter logic [23:0] AddrStep        = 24'd2
) (
   input  logic        MasterCLK,
   input  logic        Reset_n,
   input  logic        Play,
   input  logic [7:0]  SD_Data,
   input  logic        SD_DataEnable,
   input  logic        SD_DataClock,
   output logic [23:0] SD_Address,
   output logic [7:0]  Sample,
   output logic        SampleStrobe,
   output logic        BufferReady,
   output logic        Underrun,
   output logic        Overflow
);

   localparam int TickPeriod = MasterFrequency / SampleRate;
   localparam int TW         = $clog2(TickPeriod + 1);

   typedef enum logic [1:0] {BANK_EMPTY, BANK_FILLING, BANK_FULL, BANK_PLAYING} bank_t;
   typedef enum logic [1:0] {CAP_IDLE, CAP_FILL, CAP_DONE, CAP_DROP} cap_t;

   // synchronizers and edge detection
   logic [1:0] clk_sync;
   logic [1:0] en_sync;
   logic       clk_prev;
   logic       en_prev;
   logic       byte_edge;
   logic       en_s;
   logic       en_rise;

   // capture side
   cap_t       cap_state;
   cap_t       cap_next;
   logic       fill_bank;
   logic [8:0] wcnt;
   logic       start_fill;
   logic       start_bank;
   logic       commit;
   logic       abort;
   logic       drop_start;
   logic       wr_en;

   // bank bookkeeping
   bank_t      bank_state [2];
   logic       newest_full;
   logic       full0;
   logic       full1;
   logic       oldest_bank;

   // playback side
   logic [TW-1:0] tick_cnt;
   logic          tick;
   logic [8:0]    rcnt;
   logic          play_bank;
   logic [9:0]    rd_addr;
   logic          play_fire;
   logic          play_under;
   logic          promote;
   logic          promote_bank;
   logic          finish;
   logic          p1_valid;
   logic          p1_under;
   logic [7:0]    rd_data;

   logic [7:0] mem [0:1023];

   assign byte_edge = clk_sync[1] & ~clk_prev;
   assign en_s      = en_sync[1];
   assign en_rise   = en_sync[1] & ~en_prev;
   assign tick      = (tick_cnt == TW'(TickPeriod - 1));

   assign full0       = (bank_state[0] == BANK_FULL);
   assign full1       = (bank_state[1] == BANK_FULL);
   assign oldest_bank = (full0 && full1) ? ~newest_full : full1;

   assign BufferReady = (bank_state[0] == BANK_FULL) || (bank_state[0] == BANK_PLAYING) ||
                        (bank_state[1] == BANK_FULL) || (bank_state[1] == BANK_PLAYING);

   // Two-flop synchronizers for the slow reader strobes plus previous-value
   // registers for edge detection.
   always_ff @(posedge MasterCLK or negedge Reset_n) begin
      if (!Reset_n) begin
         clk_sync <= 2'b00;
         en_sync  <= 2'b00;
         clk_prev <= 1'b0;
         en_prev  <= 1'b0;
      end else begin
         clk_sync <= {clk_sync[0], SD_DataClock};
         en_sync  <= {en_sync[0], SD_DataEnable};
         clk_prev <= clk_sync[1];
         en_prev  <= en_sync[1];
      end
   end

   // Capture FSM next state: pick a free bank on sector start, count bytes,
   // and commit or abandon the sector.
   always_comb begin
      cap_next   = cap_state;
      start_fill = 1'b0;
      start_bank = 1'b0;
      commit     = 1'b0;
      abort      = 1'b0;
      drop_start = 1'b0;
      wr_en      = 1'b0;
      case (cap_state)
         CAP_IDLE: begin
            if (en_rise) begin
               if (bank_state[0] == BANK_EMPTY) begin
                  start_fill = 1'b1;
                  start_bank = 1'b0;
                  cap_next   = CAP_FILL;
               end else if (bank_state[1] == BANK_EMPTY) begin
                  start_fill = 1'b1;
                  start_bank = 1'b1;
                  cap_next   = CAP_FILL;
               end else begin
                  drop_start = 1'b1;
                  cap_next   = CAP_DROP;
               end
            end
         end
         CAP_FILL: begin
            if (!en_s) begin
               abort    = 1'b1;
               cap_next = CAP_IDLE;
            end else if (byte_edge) begin
               wr_en = 1'b1;
               if (wcnt == 9'd511) begin
                  commit   = 1'b1;
                  cap_next = CAP_DONE;
               end
            end
         end
         CAP_DONE, CAP_DROP: begin
            if (!en_s) cap_next = CAP_IDLE;
         end
         default: cap_next = CAP_IDLE;
      endcase
   end

   // Capture state, write counter, sector address and overflow flag.
   always_ff @(posedge MasterCLK or negedge Reset_n) begin
      if (!Reset_n) begin
         cap_state  <= CAP_IDLE;
         fill_bank  <= 1'b0;
         wcnt       <= 9'd0;
         SD_Address <= StartAddress;
         Overflow   <= 1'b0;
      end else begin
         cap_state <= cap_next;
         if (start_fill) begin
            fill_bank <= start_bank;
            wcnt      <= 9'd0;
         end else if (wr_en) begin
            wcnt <= wcnt + 9'd1;
         end
         if (commit) begin
            SD_Address <= (SD_Address == EndAddress) ? StartAddress : SD_Address + AddrStep;
         end
         if (drop_start) Overflow <= 1'b1;
      end
   end

   // Playback decision on a tick: continue the playing bank, promote the
   // oldest full bank, or report an underrun.
   always_comb begin
      rd_addr      = {play_bank, rcnt};
      play_fire    = 1'b0;
      play_under   = 1'b0;
      promote      = 1'b0;
      promote_bank = 1'b0;
      finish       = 1'b0;
      if (tick && Play) begin
         if (bank_state[play_bank] == BANK_PLAYING) begin
            play_fire = 1'b1;
            if (rcnt == 9'd511) finish = 1'b1;
         end else if (full0 || full1) begin
            play_fire    = 1'b1;
            promote      = 1'b1;
            promote_bank = oldest_bank;
            rd_addr      = {oldest_bank, 9'd0};
         end else begin
            play_under = 1'b1;
         end
      end
   end

   // Bank ownership. Capture only moves EMPTY/FILLING banks and playback
   // only FULL/PLAYING ones, so both may act in the same cycle.
   always_ff @(posedge MasterCLK or negedge Reset_n) begin
      if (!Reset_n) begin
         bank_state[0] <= BANK_EMPTY;
         bank_state[1] <= BANK_EMPTY;
         newest_full   <= 1'b0;
      end else begin
         if (start_fill) bank_state[start_bank] <= BANK_FILLING;
         if (commit) begin
            bank_state[fill_bank] <= BANK_FULL;
            newest_full           <= fill_bank;
         end
         if (abort) bank_state[fill_bank] <= BANK_EMPTY;
         if (promote) bank_state[promote_bank] <= BANK_PLAYING;
         if (finish) begin
            bank_state[play_bank] <= BANK_EMPTY;
            if (bank_state[~play_bank] == BANK_FULL) bank_state[~play_bank] <= BANK_PLAYING;
         end
      end
   end

   // Tick counter, read pointer and the two-stage sample output pipeline.
   always_ff @(posedge MasterCLK or negedge Reset_n) begin
      if (!Reset_n) begin
         tick_cnt     <= '0;
         rcnt         <= 9'd0;
         play_bank    <= 1'b0;
         p1_valid     <= 1'b0;
         p1_under     <= 1'b0;
         Sample       <= 8'h80;
         SampleStrobe <= 1'b0;
         Underrun     <= 1'b0;
      end else begin
         tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
         p1_valid <= play_fire | play_under;
         p1_under <= play_under;
         if (promote) begin
            play_bank <= promote_bank;
            rcnt      <= 9'd1;
         end else if (finish) begin
            rcnt <= 9'd0;
            if (bank_state[~play_bank] == BANK_FULL) play_bank <= ~play_bank;
         end else if (play_fire) begin
            rcnt <= rcnt + 9'd1;
         end
         SampleStrobe <= p1_valid;
         if (p1_valid) begin
            Sample <= p1_under ? 8'h80 : rd_data;
            if (p1_under) Underrun <= 1'b1;
         end
      end
   end

   // Simple dual-port sample RAM: capture writes, playback reads one cycle later.
   always_ff @(posedge MasterCLK) begin
      if (wr_en) mem[{fill_bank, wcnt}] <= SD_Data;
      rd_data <= mem[rd_addr];
   end

endmodule
